// File: rtl/serial_and_engine.sv
// ---------------------------------------------------------------------------
// serial_and_engine
//   Bit-serial AND of two WIDTH-bit operands, LSB first, one bit per clock.
//   Operands arrive over a valid/ready handshake. The assembled result is
//   presented over a second valid/ready handshake. There is no pipelining:
//   a new operand pair is accepted only once the previous result has been
//   handed off.
//
//   Optional feature macro: SERIAL_AND_ENGINE_OPSEL_EN
//     When defined, adds input op_sel[1:0], which is sampled with the operands.
//     It selects the per-bit function: 00 AND, 01 OR, 10 XOR, 11 NAND.
//
// Ports
//   clk        in   sole clock, rising edge
//   rst_n      in   asynchronous active-low reset
//   in_valid   in   operand pair valid
//   in_ready   out  engine can accept operands (IDLE)
//   op_a       in   [WIDTH-1:0] operand A
//   op_b       in   [WIDTH-1:0] operand B
//   op_sel     in   [1:0] function select (only with the macro above)
//   out_valid  out  result valid (DONE)
//   out_ready  in   downstream accepts result
//   res        out  [WIDTH-1:0] last completed result
//   busy       out  high while shifting
//   bit_idx    out  [IDXW-1:0] index of the bit processed this cycle (debug)
// ---------------------------------------------------------------------------
module serial_and_engine #(
  parameter  int WIDTH = 4,
  localparam int IDXW  = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
`ifdef SERIAL_AND_ENGINE_OPSEL_EN
  input  logic [1:0]       op_sel,
`endif
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] res,
  output logic             busy,
  output logic [IDXW-1:0]  bit_idx
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] sa_q, sa_d;
  logic [WIDTH-1:0] sb_q, sb_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic [IDXW-1:0]  idx_q, idx_d;
  logic             new_bit;
  logic [WIDTH-1:0] acc_shift;
`ifdef SERIAL_AND_ENGINE_OPSEL_EN
  logic [1:0]       sel_q, sel_d;
`endif

  // Single per-bit function unit; everything else is shift registers.
`ifdef SERIAL_AND_ENGINE_OPSEL_EN
  always_comb begin
    new_bit = 1'b0;
    case (sel_q)
      2'b00:   new_bit = sa_q[0] & sb_q[0];
      2'b01:   new_bit = sa_q[0] | sb_q[0];
      2'b10:   new_bit = sa_q[0] ^ sb_q[0];
      default: new_bit = ~(sa_q[0] & sb_q[0]);
    endcase
  end
`else
  assign new_bit = sa_q[0] & sb_q[0];
`endif

  // The result enters at the MSB. After WIDTH shifts, bit 0 of the operands
  // has reached bit 0 of the accumulator.
  assign acc_shift = {new_bit, acc_q[WIDTH-1:1]};

  always_comb begin
    state_d = state_q;
    sa_d    = sa_q;
    sb_d    = sb_q;
    acc_d   = acc_q;
    res_d   = res_q;
    idx_d   = idx_q;
`ifdef SERIAL_AND_ENGINE_OPSEL_EN
    sel_d   = sel_q;
`endif
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          sa_d    = op_a;
          sb_d    = op_b;
          acc_d   = '0;
          idx_d   = '0;
`ifdef SERIAL_AND_ENGINE_OPSEL_EN
          sel_d   = op_sel;
`endif
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        acc_d = acc_shift;
        sa_d  = sa_q >> 1;
        sb_d  = sb_q >> 1;
        if (idx_q == IDXW'(WIDTH - 1)) begin
          // Last bit: publish the full result on the same edge. The index
          // wraps here so it never exceeds WIDTH-1.
          res_d   = acc_shift;
          idx_d   = '0;
          state_d = DONE;
        end else begin
          idx_d = idx_q + 1'b1;
        end
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      sa_q    <= '0;
      sb_q    <= '0;
      acc_q   <= '0;
      res_q   <= '0;
      idx_q   <= '0;
`ifdef SERIAL_AND_ENGINE_OPSEL_EN
      sel_q   <= 2'b00;
`endif
    end else begin
      state_q <= state_d;
      sa_q    <= sa_d;
      sb_q    <= sb_d;
      acc_q   <= acc_d;
      res_q   <= res_d;
      idx_q   <= idx_d;
`ifdef SERIAL_AND_ENGINE_OPSEL_EN
      sel_q   <= sel_d;
`endif
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign busy      = (state_q == SHIFT);
  assign res       = res_q;
  assign bit_idx   = idx_q;

endmodule

// File: doc/serial_and_engine.md
Name: serial_and_engine

Overview:
- Bit-serial counterpart to the parallel 4-bit AND datapath.
- Accepts two WIDTH-bit operands over a valid/ready handshake.
- Computes the bitwise AND one bit per clock, LSB first, through a single AND gate.
- Presents the assembled result over a second valid/ready handshake. Used where gate count matters more than latency, and as a golden cross-check against the parallel unit.

Parameters:
- WIDTH, 4, operand/result width in bits; legal range 2..32.
- IDXW, $clog2(WIDTH), width of the bit-index counter (derived; not to be overridden).

Ports:
- clk  input  1  sole clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  operand pair valid.
- in_ready  output  1  engine can accept operands.
- op_a  input  WIDTH  operand A.
- op_b  input  WIDTH  operand B.
- out_valid  output  1  result valid.
- out_ready  input  1  downstream accepts result.
- res  output  WIDTH  result A & B.
- busy  output  1  high while in SHIFT.
- bit_idx  output  IDXW  index of the bit processed this cycle; debug only.

Behaviour:
- Interface: one clock; reset is asynchronous and active-low. All state resets on the falling edge of rst_n, with no clock required.
- Reset values:
  - in_ready=1, out_valid=0, res=0, busy=0, bit_idx=0.
  - Internal shift registers = 0, state=IDLE.
- FSM states: IDLE, SHIFT, DONE.
- IDLE:
  - in_ready=1.
  - On in_valid&&in_ready at an edge: load op_a/op_b into shift regs sa/sb, clear the result shift reg, set bit_idx=0, go to SHIFT.
  - Operands are sampled only on that edge; later changes are ignored.
- SHIFT:
  - in_ready=0, busy=1.
  - Each cycle: result reg shifts right with (sa[0]&sb[0]) entering at MSB; sa, sb shift right; bit_idx increments.
  - After the bit with bit_idx==WIDTH-1: go to DONE; res is updated from the full result reg on the same edge.
- DONE:
  - out_valid=1; res held stable while out_valid=1 && out_ready=0.
  - On out_valid&&out_ready: out_valid drops, go to IDLE.
  - res keeps its last value after handoff until the next result is produced.
- Latency: accept edge at cycle 0 → out_valid high at cycle WIDTH+1. Throughput is one result per WIDTH+2 cycles with out_ready held high.
- No pipelining: in_ready is low in SHIFT and DONE. An in_valid arriving then is back-pressured, not dropped.
- out_ready asserted in IDLE or SHIFT has no effect.
- bit_idx wraps to 0 on entry to DONE. With a non-power-of-two WIDTH the counter never exceeds WIDTH-1.
- Reset mid-operation: the in-flight computation is discarded with no partial result output. The first cycle after reset release is IDLE with in_ready=1.
- Operands all-ones or all-zeros are not special-cased.

Optional Feature:
- Macro: SERIAL_AND_ENGINE_OPSEL_EN.
- When defined:
  - Adds input op_sel[1:0], sampled with the operands on the accept edge.
  - Per-bit function: 00 AND, 01 OR, 10 XOR, 11 NAND.
  - Latency and handshake are unchanged.
- When undefined: the port is absent and the function is always AND.

Test Plan:
- Reset, then op_a=4'b1011, op_b=4'b0110, in_valid for one cycle, out_ready=1 → in_ready low for 5 cycles; out_valid high at cycle 5 with res=4'b0010; back to IDLE next cycle.
- op_a=4'hF, op_b=4'hF then op_a=4'h0, op_b=4'hA, issued back-to-back → res=4'hF then 4'h0. The second operand pair is held off until in_ready returns.
- Result 4'b1000 (1100 & 1010) with out_ready=0 for 10 cycles after out_valid → res and out_valid held constant; a single handoff occurs when out_ready rises.
- Assert rst_n=0 asynchronously mid-SHIFT (bit_idx=2) → all outputs at reset values immediately, with no out_valid pulse afterward; a new op 0x5&0x7 yields res=4'h5.
- WIDTH=8: op_a=8'hC3, op_b=8'h5A → res=8'h42 at cycle 9.
- With SERIAL_AND_ENGINE_OPSEL_EN, op_sel=2'b10, op_a=4'b1100, op_b=4'b1010 → res=4'b0110; with op_sel=2'b11 → 4'b0111.
